// File: rtl/systolic_feed_sequencer.sv
// Feed sequencer for the systolic array. It streams K operand vectors from
// DPRAM ports A/B into the left/top double buffers, swaps the buffers and
// drives the shift/accumulate enables, then flushes the array pipeline.
module systolic_feed_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int MATRIX_SIZE   = 8,
  parameter int ADDR_WIDTH    = $clog2(MATRIX_SIZE),
  parameter int DP_ADDR_WIDTH = 10,
  parameter int K_WIDTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DP_ADDR_WIDTH-1:0] base_a,
  input  logic [DP_ADDR_WIDTH-1:0] base_b,
  input  logic [K_WIDTH-1:0]       k_len,
  output logic                     busy,
  output logic                     done,
  output logic [DP_ADDR_WIDTH-1:0] addr_a,
  output logic [DP_ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0]    dout_a,
  input  logic [DATA_WIDTH-1:0]    dout_b,
  output logic                     load_en_left,
  output logic                     load_en_top,
  output logic [ADDR_WIDTH-1:0]    addr_left,
  output logic [ADDR_WIDTH-1:0]    addr_top,
  output logic [DATA_WIDTH-1:0]    data_in_left,
  output logic [DATA_WIDTH-1:0]    data_in_top,
  output logic                     swap_buffers_left,
  output logic                     swap_buffers_top,
  output logic                     shift_en_right,
  output logic                     shift_en_down,
  output logic                     acc_en,
  output logic                     acc_rst
);

  // Phase counter must reach 2M-3 (last FLUSH cycle).
  localparam int CW = $clog2(2 * MATRIX_SIZE);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * MATRIX_SIZE - 3);
  localparam logic [DP_ADDR_WIDTH-1:0] M_STEP = DP_ADDR_WIDTH'(MATRIX_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_DRAIN, S_SWAP, S_SHIFT, S_FLUSH, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [K_WIDTH-1:0]       k_q, k_d, klen_q, klen_d;
  logic [DP_ADDR_WIDTH-1:0] off_q, off_d;
  logic [DP_ADDR_WIDTH-1:0] base_a_q, base_a_d, base_b_q, base_b_d;
  logic [K_WIDTH:0]         k_inc;

  // Registered outputs, computed from the next state so they line up with it.
  logic                     busy_q, busy_d, done_q, done_d;
  logic                     acc_rst_q, acc_rst_d, swap_q, swap_d, run_q, run_d;
  logic                     load_q, load_d;
  logic [ADDR_WIDTH-1:0]    idx_q, idx_d;
  logic [DP_ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;

  assign k_inc = {1'b0, k_q} + 1'b1;

  // Next-state and counter update for the matmul sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    klen_d   = klen_q;
    off_d    = off_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (k_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_CLEAR;
            base_a_d = base_a;
            base_b_d = base_b;
            klen_d   = k_len;
            k_d      = '0;
            off_d    = '0;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_SWAP;
      S_SWAP: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          k_d     = k_inc[K_WIDTH-1:0];
          off_d   = off_q + M_STEP;
          state_d = (k_inc < {1'b0, klen_q}) ? S_LOAD : S_FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort cancels any busy state; IDLE and DONE are unaffected.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d = S_IDLE;
    end
  end

  // Output decode; buffer writes trail the LOAD read by one cycle.
  always_comb begin
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    acc_rst_d = (state_d == S_CLEAR);
    swap_d    = (state_d == S_SWAP);
    run_d     = (state_d == S_SHIFT) || (state_d == S_FLUSH);
    addr_a_d  = '0;
    addr_b_d  = '0;
    if (state_d == S_LOAD) begin
      addr_a_d = base_a_q + off_d + DP_ADDR_WIDTH'(cnt_d);
      addr_b_d = base_b_q + off_d + DP_ADDR_WIDTH'(cnt_d);
    end
    load_d = (state_q == S_LOAD) && !abort;
    idx_d  = load_d ? cnt_q[ADDR_WIDTH-1:0] : '0;
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      klen_q    <= '0;
      off_q     <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_rst_q <= 1'b0;
      swap_q    <= 1'b0;
      run_q     <= 1'b0;
      load_q    <= 1'b0;
      idx_q     <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      klen_q    <= klen_d;
      off_q     <= off_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_rst_q <= acc_rst_d;
      swap_q    <= swap_d;
      run_q     <= run_d;
      load_q    <= load_d;
      idx_q     <= idx_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign acc_rst           = acc_rst_q;
  assign addr_a            = addr_a_q;
  assign addr_b            = addr_b_q;
  assign load_en_left      = load_q;
  assign load_en_top       = load_q;
  assign addr_left         = idx_q;
  assign addr_top          = idx_q;
  // RAM read data is already registered; pass it straight through while writing.
  assign data_in_left      = load_q ? dout_a : '0;
  assign data_in_top       = load_q ? dout_b : '0;
  assign swap_buffers_left = swap_q;
  assign swap_buffers_top  = swap_q;
  assign shift_en_right    = run_q;
  assign shift_en_down     = run_q;
  assign acc_en            = run_q;

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Scoreboard bench for systolic_feed_sequencer (M=8). Expected per-cycle
// output records are queued when a run is issued; the monitor pops one for
// every cycle the DUT shows any activity.
module tb_systolic_feed_sequencer;

  localparam int M = 8;

  typedef struct packed {
    logic [15:0] cyc;
    logic        busy, done, acc_rst;
    logic [9:0]  aa, ab;
    logic        le_l, le_t;
    logic [2:0]  il, it;
    logic [7:0]  dl, dt;
    logic        sw_l, sw_t, shr, shd, acc;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [9:0] base_a, base_b;
  logic [7:0] k_len;
  logic       busy, done;
  logic [9:0] addr_a, addr_b;
  logic [7:0] dout_a, dout_b;
  logic       load_en_left, load_en_top;
  logic [2:0] addr_left, addr_top;
  logic [7:0] data_in_left, data_in_top;
  logic       swap_buffers_left, swap_buffers_top;
  logic       shift_en_right, shift_en_down, acc_en, acc_rst;

  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];

  int   cyc = 0;
  int   t0 = 0;
  int   checks = 0;
  int   failures = 0;
  int   drain_req = 0;
  int   drain_done = 0;
  rec_t q[$];

  systolic_feed_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_a(base_a), .base_b(base_b), .k_len(k_len),
    .busy(busy), .done(done), .addr_a(addr_a), .addr_b(addr_b),
    .dout_a(dout_a), .dout_b(dout_b),
    .load_en_left(load_en_left), .load_en_top(load_en_top),
    .addr_left(addr_left), .addr_top(addr_top),
    .data_in_left(data_in_left), .data_in_top(data_in_top),
    .swap_buffers_left(swap_buffers_left), .swap_buffers_top(swap_buffers_top),
    .shift_en_right(shift_en_right), .shift_en_down(shift_en_down),
    .acc_en(acc_en), .acc_rst(acc_rst)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DPRAM read ports, one-cycle latency
  always @(posedge clk) begin
    dout_a <= mem_a[addr_a];
    dout_b <= mem_b[addr_b];
  end

  // Queue the expected activity of one run; records after cycle 'cut' are dropped.
  task automatic build(input int ba, input int bb, input int kk, input int cut);
    rec_t e [0:255];
    int last;
    for (int c = 0; c < 256; c++) e[c] = '0;
    if (kk == 0) begin
      e[1].done = 1'b1;
      last = 1;
    end else begin
      int f;
      e[1].busy = 1'b1;
      e[1].acc_rst = 1'b1;
      for (int k = 0; k < kk; k++) begin
        int s;
        s = 2 + k * (2 * M + 2);
        for (int i = 0; i < M; i++) begin
          int a, b;
          a = (ba + k * M + i) % 1024;
          b = (bb + k * M + i) % 1024;
          e[s+i].busy   = 1'b1;
          e[s+i].aa     = 10'(a);
          e[s+i].ab     = 10'(b);
          e[s+i+1].busy = 1'b1;
          e[s+i+1].le_l = 1'b1;
          e[s+i+1].le_t = 1'b1;
          e[s+i+1].il   = 3'(i);
          e[s+i+1].it   = 3'(i);
          e[s+i+1].dl   = mem_a[a];
          e[s+i+1].dt   = mem_b[b];
        end
        e[s+M+1].busy = 1'b1;
        e[s+M+1].sw_l = 1'b1;
        e[s+M+1].sw_t = 1'b1;
        for (int i = 0; i < M; i++) begin
          e[s+M+2+i].busy = 1'b1;
          e[s+M+2+i].shr  = 1'b1;
          e[s+M+2+i].shd  = 1'b1;
          e[s+M+2+i].acc  = 1'b1;
        end
      end
      f = 2 + kk * (2 * M + 2);
      for (int i = 0; i < 2 * M - 2; i++) begin
        e[f+i].busy = 1'b1;
        e[f+i].shr  = 1'b1;
        e[f+i].shd  = 1'b1;
        e[f+i].acc  = 1'b1;
      end
      last = f + 2 * M - 2;
      e[last].done = 1'b1;
    end
    for (int c = 1; c <= last; c++) begin
      if (c <= cut) begin
        e[c].cyc = 16'(c);
        q.push_back(e[c]);
      end
    end
  endtask

  // Pulse start for one cycle (cycle 0), then scramble the operands.
  task automatic go(input int ba, input int bb, input int kk);
    @(posedge clk); #1;
    base_a = 10'(ba);
    base_b = 10'(bb);
    k_len  = 8'(kk);
    start  = 1'b1;
    t0     = cyc;
    @(posedge clk); #1;
    start  = 1'b0;
    base_a = 10'h2AA;
    base_b = 10'h155;
    k_len  = 8'hFF;
  endtask

  task automatic wait_until(input int n);
    while ((cyc - t0) < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    drain_req = drain_req + 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every active cycle against the queue
  initial begin
    rec_t a, x;
    forever begin
      @(negedge clk);
      a.cyc = '0;
      a.busy = busy; a.done = done; a.acc_rst = acc_rst;
      a.aa = addr_a; a.ab = addr_b;
      a.le_l = load_en_left; a.le_t = load_en_top;
      a.il = addr_left; a.it = addr_top;
      a.dl = data_in_left; a.dt = data_in_top;
      a.sw_l = swap_buffers_left; a.sw_t = swap_buffers_top;
      a.shr = shift_en_right; a.shd = shift_en_down; a.acc = acc_en;
      if (!rst_n) begin
        checks++;
        if (a != '0) begin
          failures++;
          $display("FAIL reset_outputs t=%0t actual=%h required=0", $time, a);
        end
      end else if (a != '0) begin
        a.cyc = 16'(cyc - t0);
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output actual=%h required=idle", a);
        end else begin
          x = q.pop_front();
          if (a !== x) begin
            failures++;
            $display("FAIL cycle_record actual=%h required=%h", a, x);
          end
        end
      end
      if (drain_req != drain_done) begin
        drain_done = drain_done + 1;
        checks++;
        if (q.size() != 0) begin
          failures++;
          $display("FAIL missing_output actual_left=%0d required=0 next=%h", q.size(), q[0]);
          q.delete();
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'((i * 7 + 3) ^ (i >> 3));
      mem_b[i] = 8'(i * 13 + 85);
    end
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    base_a = '0; base_b = '0; k_len = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // K=1 basic run, done at 34
    build(0, 'h40, 1, 1000); go(0, 'h40, 1); wait_until(40); drain();
    // K=3, done at 70
    build('h100, 'h200, 3, 1000); go('h100, 'h200, 3); wait_until(76); drain();
    // K=0: done at cycle 1 only
    build(5, 6, 0, 1000); go(5, 6, 0); wait_until(8); drain();
    // address wrap
    build('h3FC, 'h3F8, 1, 1000); go('h3FC, 'h3F8, 1); wait_until(40); drain();
    // abort mid-LOAD at cycle 5
    build(0, 'h40, 1, 5); go(0, 'h40, 1); wait_until(5);
    abort = 1'b1; @(posedge clk); #1 abort = 1'b0;
    wait_until(40); drain();
    // restart after abort, K=2
    build('h20, 'h60, 2, 1000); go('h20, 'h60, 2); wait_until(60); drain();
    // abort and start together in IDLE: nothing starts
    @(posedge clk); #1;
    k_len = 8'd1; start = 1'b1; abort = 1'b1; t0 = cyc;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    wait_until(20); drain();
    // start re-pulsed at cycles 10 and 34 is ignored
    build('h80, 'hC0, 1, 1000); go('h80, 'hC0, 1); wait_until(10);
    k_len = 8'd5; base_a = 10'h155; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_until(34); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_until(45); drain();
    // async reset mid-SHIFT at cycle 15
    build('h10, 'h50, 1, 14); go('h10, 'h50, 1); wait_until(15);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drain();
    // normal run after reset
    build('h30, 'h70, 1, 1000); go('h30, 'h70, 1); wait_until(40); drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_feed_sequencer.md
# systolic_feed_sequencer

Autonomous sequencer that streams operand vectors from the dual-port RAM into the systolic array's left and top double buffers, swaps them and drives the shift/accumulate strobes for a full K-step matrix multiply. It sits between the instruction FSM, which issues one `start` per matmul, and the `systolic_module`/`dp_ram` pair. It owns DPRAM ports A (left operand) and B (top operand) while busy.

## Interface
- `DATA_WIDTH`, 8: operand width.
- `MATRIX_SIZE`, 8: array dimension M, with M ≥ 2.
- `ADDR_WIDTH`, `$clog2(MATRIX_SIZE)`: buffer element index width.
- `DP_ADDR_WIDTH`, 10: DPRAM address width.
- `K_WIDTH`, 8: width of the vector-count field.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled in IDLE only.
- `abort` in 1: synchronous cancel.
- `base_a` in DP_ADDR_WIDTH: first address of the A-operand vectors.
- `base_b` in DP_ADDR_WIDTH: first address of the B-operand vectors.
- `k_len` in K_WIDTH: number of vectors K.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `addr_a` out DP_ADDR_WIDTH: DPRAM port A read address.
- `addr_b` out DP_ADDR_WIDTH: DPRAM port B read address.
- `dout_a` in DATA_WIDTH: DPRAM port A read data; 1-cycle read latency.
- `dout_b` in DATA_WIDTH: DPRAM port B read data; 1-cycle read latency.
- `load_en_left` out 1: left buffer write strobe.
- `load_en_top` out 1: top buffer write strobe.
- `addr_left` out ADDR_WIDTH: left buffer element index.
- `addr_top` out ADDR_WIDTH: top buffer element index.
- `data_in_left` out DATA_WIDTH: left buffer write data.
- `data_in_top` out DATA_WIDTH: top buffer write data.
- `swap_buffers_left` out 1: left buffer swap pulse.
- `swap_buffers_top` out 1: top buffer swap pulse.
- `shift_en_right` out 1: array shift-right enable.
- `shift_en_down` out 1: array shift-down enable.
- `acc_en` out 1: accumulator enable.
- `acc_rst` out 1: accumulator clear pulse.

## Operation
- All outputs are registered.
- Reset value of every output is 0, and the FSM resets to IDLE.
- The write-side DPRAM port signals are not driven here. The team ties `we_a` and `we_b` low while `busy` is high.

States and transitions:
- IDLE:
  - If `start` is high and `k_len` = 0, go to DONE.
  - If `start` is high and `k_len` ≠ 0, latch `base_a`, `base_b` and `k_len`, set k=0, and go to CLEAR.
- CLEAR, 1 cycle: `acc_rst`=1, then go to LOAD.
- LOAD, M cycles with i = 0..M-1:
  - `addr_a` = base_a + k·M + i.
  - `addr_b` = base_b + k·M + i.
  - After i = M-1, go to DRAIN.
- Buffer writes:
  - Each read returns one cycle later.
  - In that cycle, `load_en_left` and `load_en_top` are 1.
  - The data is `data_in_left`=`dout_a` and `data_in_top`=`dout_b`.
  - The index is `addr_left`=`addr_top`= the i of the previous cycle.
- DRAIN, 1 cycle: the last buffer write (i=M-1) occurs. Then go to SWAP.
- SWAP, 1 cycle: `swap_buffers_left`=`swap_buffers_top`=1. Then go to SHIFT.
- SHIFT, M cycles: `shift_en_right`=`shift_en_down`=`acc_en`=1.
  - Then k++.
  - If k < K, go to LOAD; otherwise go to FLUSH.
- FLUSH, 2M-2 cycles: the same three enables stay at 1. Then go to DONE.
- DONE, 1 cycle: `done`=1, then go to IDLE.

Output qualification:
- `busy` is 1 in CLEAR, LOAD, DRAIN, SWAP, SHIFT and FLUSH.
- `busy` is 0 in IDLE and DONE.
- `addr_a` and `addr_b` are 0 outside LOAD.
- `load_en_*`, `swap_*`, `shift_*` and `acc_*` are 0 outside the states listed above.

Address arithmetic:
- Addresses are computed modulo 2^DP_ADDR_WIDTH, so wrap-around past the top address is silent and not flagged.
- k·M uses a running offset register incremented by M per vector. No multiplier.

Boundary conditions:
- `start` while busy, or in DONE, is ignored.
- `k_len`, `base_a` and `base_b` changes after start have no effect.
- `abort` in any busy state goes to IDLE next cycle:
  - All strobes are 0 from that cycle on.
  - `done` is not pulsed.
  - A pending buffer write from the last LOAD read is dropped.
- `abort` and `start` together in IDLE: `abort` wins, and the sequence does not start.
- `rst_n` low at any time asynchronously clears the FSM and counters, and forces all outputs to 0 immediately.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high; `busy` rises at cycle 1.
- Per vector: M + 1 + 1 + M = 2M+2 cycles.
- Busy cycles total 1 + K(2M+2) + (2M-2).
- `done` is high in the cycle after the last busy cycle.
- With M=8, K=1: `busy` is high in cycles 1–33 and `done` is high in cycle 34.
- With K=0: `done` is high in cycle 1 and `busy` never rises.
- A new `start` is accepted at the earliest in the cycle after `done`.
- DPRAM read latency is fixed at 1 cycle. Buffer write data is taken from `dout_*` with no extra register stage.

## Test plan
- M=8, K=1, `base_a`=0x000, `base_b`=0x040 -> the following, all cycle-exact:
  - `acc_rst` at cycle 1.
  - `addr_a` = 0..7 and `addr_b` = 0x40..0x47 in cycles 2–9.
  - `load_en_*` in cycles 3–10 with index 0..7 and data equal to the RAM contents.
  - Swap at cycle 11.
  - Shift/acc enables in cycles 12–33.
  - `done` at cycle 34.
- K=3, `base_a`=0x100 -> `addr_a` runs 0x100–0x107, then 0x108–0x10F, then 0x110–0x117; exactly 3 swap pulses; `done` at cycle 1+54+14+1 = 70.
- `k_len`=0 -> `done` at cycle 1; no strobe ever asserted; `busy` stays 0.
- `base_a`=0x3FC, K=1 -> `addr_a` sequence is 0x3FC, 0x3FD, 0x3FE, 0x3FF, 0x000, 0x001, 0x002, 0x003.
- `abort` at cycle 5 (mid-LOAD) -> all outputs 0 from cycle 6; no `done`. A subsequent `start` restarts from `acc_rst` with k=0.
- `start` re-pulsed at cycles 10 and 34 of a K=1 run -> both ignored, with a single `done` at cycle 34.
- `rst_n` pulsed low mid-SHIFT -> outputs go to 0 immediately, the FSM is in IDLE after release, and `start` works normally afterwards.
